// File: rtl/lnrv_exu_gpr_pkg.sv
// Shared constants for the EXU integer register file slice.
package lnrv_exu_gpr_pkg;

    localparam int XLEN_DFLT    = 32;
    localparam int GPR_NUM_DFLT = 32;
    localparam int GPR_IDX_W    = $clog2(GPR_NUM_DFLT);

    typedef logic [GPR_IDX_W-1:0] gpr_idx_t;
    typedef logic [XLEN_DFLT-1:0] gpr_data_t;

endpackage : lnrv_exu_gpr_pkg

// File: rtl/lnrv_exu_gpr_if.sv
// EXU writeback channel: vld/rdy write transaction into the register file.
interface lnrv_exu_gpr_if #(
    parameter int XLEN  = 32,
    parameter int IDX_W = 5
);

    logic             gpr_wbck_vld;
    logic             gpr_wbck_rdy;
    logic [IDX_W-1:0] gpr_wbck_idx;
    logic [XLEN-1:0]  gpr_wbck_wdata;

    // Producer of writeback results (EXU side).
    modport master (
        output gpr_wbck_vld,
        output gpr_wbck_idx,
        output gpr_wbck_wdata,
        input  gpr_wbck_rdy
    );

    // Register file side.
    modport slave (
        input  gpr_wbck_vld,
        input  gpr_wbck_idx,
        input  gpr_wbck_wdata,
        output gpr_wbck_rdy
    );

endinterface : lnrv_exu_gpr_if

// File: rtl/lnrv_gpr_scbd.sv
// Pending-write scoreboard: one busy bit per GPR, set at dispatch, cleared at
// writeback, cleared wholesale on flush. Entry 0 is never busy.
module lnrv_gpr_scbd #(
    parameter  int GPR_NUM = 32,
    localparam int IDX_W   = $clog2(GPR_NUM)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx,
    input  logic             flush,
    input  logic [IDX_W-1:0] rs1_idx,
    input  logic [IDX_W-1:0] rs2_idx,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             rd_busy
);

    logic [GPR_NUM-1:0] busy_q;
    logic [GPR_NUM-1:0] busy_d;

    // Next busy vector: clear first so a same-index set wins, flush overrides all.
    always_comb begin
        // NOTE: assigning the full default first means every path writes busy_d, so no latch is inferred.
        busy_d = busy_q;
        if (clr_en) busy_d[clr_idx] = 1'b0;
        if (set_en) busy_d[set_idx] = 1'b1;
        if (flush)  busy_d = '0;
        busy_d[0] = 1'b0;
    end

    // Busy vector state register.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: non-blocking assignments keep every flop sampling pre-edge values regardless of block order.
        if (!rst_n) busy_q <= '0;
        else        busy_q <= busy_d;
    end

    // Raw lookups; write-bypass suppression is applied by the parent.
    assign rs1_busy = busy_q[rs1_idx];
    assign rs2_busy = busy_q[rs2_idx];
    assign rd_busy  = busy_q[rd_idx];

endmodule : lnrv_gpr_scbd

// File: rtl/lnrv_exu_gpr.sv
// Integer register file: 32x32 GPRs (x0 reads zero), writeback channel,
// two combinational read ports with same-cycle write bypass, and RAW/WAW
// hazard reporting through the pending-write scoreboard.
module lnrv_exu_gpr
    import lnrv_exu_gpr_pkg::*;
#(
    parameter  int XLEN      = XLEN_DFLT,
    parameter  int GPR_NUM   = GPR_NUM_DFLT,
    parameter  bit BYPASS_EN = 1'b1,
    localparam int IDX_W     = $clog2(GPR_NUM)
) (
    input  logic             clk,
    input  logic             rst_n,
    lnrv_exu_gpr_if.slave    wbck,
    input  logic [IDX_W-1:0] rs1_idx,
    input  logic [IDX_W-1:0] rs2_idx,
    output logic [XLEN-1:0]  rs1_rdata,
    output logic [XLEN-1:0]  rs2_rdata,
    input  logic             disp_vld,
    input  logic             disp_rd_en,
    input  logic [IDX_W-1:0] disp_rd_idx,
    output logic             rs1_busy,
    output logic             rs2_busy,
    output logic             rd_busy,
    input  logic             flush
);

    logic [XLEN-1:0] gpr_q [GPR_NUM];
    logic            rdy_q;
    logic            rdy_d;
    logic            wb_fire;
    logic            wr_en;
    logic            disp_set;
    logic            rs1_byp;
    logic            rs2_byp;
    logic            rs1_busy_raw;
    logic            rs2_busy_raw;

    // Ready is a pure register so there is no combinational vld->rdy path.
    assign rdy_d             = 1'b1;
    assign wbck.gpr_wbck_rdy = rdy_q;

    assign wb_fire  = wbck.gpr_wbck_vld & rdy_q;
    assign wr_en    = wb_fire & (wbck.gpr_wbck_idx != '0);
    assign disp_set = disp_vld & disp_rd_en & (disp_rd_idx != '0);

    // Ready register: low through reset, high from the first edge after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) rdy_q <= 1'b0;
        else        rdy_q <= rdy_d;
    end

    // Register array; entry 0 is never written so it stays zero.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: the array is reset because architectural state must read zero after reset; this forces flops, not RAM.
        if (!rst_n) begin
            for (int i = 0; i < GPR_NUM; i++) gpr_q[i] <= '0;
        end else if (wr_en) begin
            gpr_q[wbck.gpr_wbck_idx] <= wbck.gpr_wbck_wdata;
        end
    end

    // A firing write to the same nonzero index forwards to the read port.
    assign rs1_byp = BYPASS_EN & wr_en & (wbck.gpr_wbck_idx == rs1_idx);
    assign rs2_byp = BYPASS_EN & wr_en & (wbck.gpr_wbck_idx == rs2_idx);

    // Read port muxes: zero for x0, bypass data, else array contents.
    always_comb begin
        rs1_rdata = gpr_q[rs1_idx];
        if (rs1_idx == '0) rs1_rdata = '0;
        else if (rs1_byp)  rs1_rdata = wbck.gpr_wbck_wdata;

        rs2_rdata = gpr_q[rs2_idx];
        if (rs2_idx == '0) rs2_rdata = '0;
        else if (rs2_byp)  rs2_rdata = wbck.gpr_wbck_wdata;
    end

    lnrv_gpr_scbd #(
        .GPR_NUM (GPR_NUM)
    ) u_scbd (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (disp_set),
        .set_idx  (disp_rd_idx),
        .clr_en   (wr_en),
        .clr_idx  (wbck.gpr_wbck_idx),
        .flush    (flush),
        .rs1_idx  (rs1_idx),
        .rs2_idx  (rs2_idx),
        .rd_idx   (disp_rd_idx),
        .rs1_busy (rs1_busy_raw),
        .rs2_busy (rs2_busy_raw),
        .rd_busy  (rd_busy)
    );

    // A retiring write to the source hides its busy bit in the same cycle.
    assign rs1_busy = rs1_busy_raw & ~rs1_byp;
    assign rs2_busy = rs2_busy_raw & ~rs2_byp;

endmodule : lnrv_exu_gpr

// File: tb/tb_lnrv_exu_gpr.sv
// Directed bench for lnrv_exu_gpr: table of per-cycle vectors plus
// hand-written reset-release and asynchronous-reset sequences.
module tb_lnrv_exu_gpr;

    logic        clk;
    logic        rst_n;
    logic [4:0]  rs1_idx;
    logic [4:0]  rs2_idx;
    logic [31:0] rs1_rdata;
    logic [31:0] rs2_rdata;
    logic        disp_vld;
    logic        disp_rd_en;
    logic [4:0]  disp_rd_idx;
    logic        rs1_busy;
    logic        rs2_busy;
    logic        rd_busy;
    logic        flush;

    int total = 0;
    int bad   = 0;

    lnrv_exu_gpr_if #(.XLEN(32), .IDX_W(5)) wbck_if ();

    lnrv_exu_gpr #(.XLEN(32), .GPR_NUM(32), .BYPASS_EN(1'b1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .wbck        (wbck_if.slave),
        .rs1_idx     (rs1_idx),
        .rs2_idx     (rs2_idx),
        .rs1_rdata   (rs1_rdata),
        .rs2_rdata   (rs2_rdata),
        .disp_vld    (disp_vld),
        .disp_rd_en  (disp_rd_en),
        .disp_rd_idx (disp_rd_idx),
        .rs1_busy    (rs1_busy),
        .rs2_busy    (rs2_busy),
        .rd_busy     (rd_busy),
        .flush       (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wb_vld;
        logic [4:0]  wb_idx;
        logic [31:0] wb_data;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        dv;
        logic        den;
        logic [4:0]  drd;
        logic        fl;
        logic [31:0] e_rs1;
        logic [31:0] e_rs2;
        logic        e_b1;
        logic        e_b2;
        logic        e_rdb;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(
        input logic wb_vld, input logic [4:0] wb_idx, input logic [31:0] wb_data,
        input logic [4:0] rs1, input logic [4:0] rs2,
        input logic dv, input logic den, input logic [4:0] drd, input logic fl,
        input logic [31:0] e_rs1, input logic [31:0] e_rs2,
        input logic e_b1, input logic e_b2, input logic e_rdb);
        vec_t v;
        v.wb_vld = wb_vld; v.wb_idx = wb_idx; v.wb_data = wb_data;
        v.rs1 = rs1; v.rs2 = rs2; v.dv = dv; v.den = den; v.drd = drd; v.fl = fl;
        v.e_rs1 = e_rs1; v.e_rs2 = e_rs2; v.e_b1 = e_b1; v.e_b2 = e_b2; v.e_rdb = e_rdb;
        return v;
    endfunction

    task automatic drive_idle();
        wbck_if.gpr_wbck_vld   = 1'b0;
        wbck_if.gpr_wbck_idx   = '0;
        wbck_if.gpr_wbck_wdata = '0;
        disp_vld    = 1'b0;
        disp_rd_en  = 1'b0;
        disp_rd_idx = '0;
        flush       = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //           wb  idx  data           rs1 rs2 dv den drd fl  e_rs1          e_rs2         b1 b2 rdb
        vecs[0]  = mk(1, 5,  32'hDEADBEEF,   5,  0,  0, 0,  0, 0, 32'hDEADBEEF, 32'h0,        0, 0, 0);
        vecs[1]  = mk(0, 0,  32'h0,          5,  5,  0, 0,  0, 0, 32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 0);
        vecs[2]  = mk(1, 0,  32'h12345678,   0,  0,  0, 0,  0, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[3]  = mk(0, 0,  32'h0,          0,  0,  0, 0,  0, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[4]  = mk(0, 0,  32'h0,          0,  7,  1, 1,  7, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[5]  = mk(0, 0,  32'h0,          5,  7,  0, 0,  7, 0, 32'hDEADBEEF, 32'h0,        0, 1, 1);
        vecs[6]  = mk(1, 7,  32'h55,         5,  7,  0, 0,  7, 0, 32'hDEADBEEF, 32'h55,       0, 0, 1);
        vecs[7]  = mk(0, 0,  32'h0,          5,  7,  0, 0,  7, 0, 32'hDEADBEEF, 32'h55,       0, 0, 0);
        vecs[8]  = mk(1, 9,  32'h99,         9,  0,  1, 1,  9, 0, 32'h99,       32'h0,        0, 0, 0);
        vecs[9]  = mk(0, 0,  32'h0,          9,  0,  0, 0,  9, 0, 32'h99,       32'h0,        1, 0, 1);
        vecs[10] = mk(0, 0,  32'h0,          3,  9,  1, 1,  3, 0, 32'h0,        32'h99,       0, 1, 0);
        vecs[11] = mk(0, 0,  32'h0,          3,  4,  1, 1,  4, 0, 32'h0,        32'h0,        1, 0, 0);
        vecs[12] = mk(0, 0,  32'h0,          4, 10,  1, 1, 10, 0, 32'h0,        32'h0,        1, 0, 0);
        vecs[13] = mk(1, 3,  32'h33,        10, 11,  1, 1, 11, 1, 32'h0,        32'h0,        1, 0, 0);
        vecs[14] = mk(0, 0,  32'h0,         11,  3,  0, 0, 10, 0, 32'h0,        32'h33,       0, 0, 0);
        vecs[15] = mk(0, 0,  32'h0,          9,  4,  0, 0,  3, 0, 32'h99,       32'h0,        0, 0, 0);
        vecs[16] = mk(0, 0,  32'h0,          5,  0,  1, 1,  5, 0, 32'hDEADBEEF, 32'h0,        0, 0, 0);
        vecs[17] = mk(1, 5,  32'h5A5A,       5, 12,  1, 1, 12, 0, 32'h5A5A,     32'h0,        0, 0, 0);
        vecs[18] = mk(0, 0,  32'h0,          5, 12,  0, 0,  5, 0, 32'h5A5A,     32'h0,        0, 1, 0);
        vecs[19] = mk(0, 0,  32'h0,         13, 12,  1, 0, 13, 0, 32'h0,        32'h0,        0, 1, 0);
        vecs[20] = mk(0, 0,  32'h0,         13,  0,  0, 0, 13, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[21] = mk(0, 0,  32'h0,          0,  0,  1, 1,  0, 0, 32'h0,        32'h0,        0, 0, 0);
        vecs[22] = mk(0, 0,  32'h0,          0,  0,  0, 0,  0, 0, 32'h0,        32'h0,        0, 0, 0);

        // Reset state.
        drive_idle();
        rst_n   = 1'b0;
        rs1_idx = 5'd6;
        rs2_idx = 5'd0;
        #12;
        check("reset rdy", {31'b0, wbck_if.gpr_wbck_rdy}, 32'h0);
        check("reset rs1_rdata", rs1_rdata, 32'h0);
        check("reset busy", {29'b0, rs1_busy, rs2_busy, rd_busy}, 32'h0);

        // Release between edges with a write offered: not ready, so not taken.
        rst_n = 1'b1;
        wbck_if.gpr_wbck_vld   = 1'b1;
        wbck_if.gpr_wbck_idx   = 5'd6;
        wbck_if.gpr_wbck_wdata = 32'hBAD0BAD0;
        #1;
        check("rdy low before first edge", {31'b0, wbck_if.gpr_wbck_rdy}, 32'h0);
        check("no bypass while not ready", rs1_rdata, 32'h0);
        next_cycle();
        wbck_if.gpr_wbck_vld = 1'b0;
        #1;
        check("rdy high after first edge", {31'b0, wbck_if.gpr_wbck_rdy}, 32'h1);
        check("unready write dropped", rs1_rdata, 32'h0);

        // Table-driven vectors, one per cycle.
        for (int i = 0; i < NVEC; i++) begin
            wbck_if.gpr_wbck_vld   = vecs[i].wb_vld;
            wbck_if.gpr_wbck_idx   = vecs[i].wb_idx;
            wbck_if.gpr_wbck_wdata = vecs[i].wb_data;
            rs1_idx     = vecs[i].rs1;
            rs2_idx     = vecs[i].rs2;
            disp_vld    = vecs[i].dv;
            disp_rd_en  = vecs[i].den;
            disp_rd_idx = vecs[i].drd;
            flush       = vecs[i].fl;
            #1;
            check($sformatf("v%0d rs1_rdata", i), rs1_rdata, vecs[i].e_rs1);
            check($sformatf("v%0d rs2_rdata", i), rs2_rdata, vecs[i].e_rs2);
            check($sformatf("v%0d rs1_busy", i), {31'b0, rs1_busy}, {31'b0, vecs[i].e_b1});
            check($sformatf("v%0d rs2_busy", i), {31'b0, rs2_busy}, {31'b0, vecs[i].e_b2});
            check($sformatf("v%0d rd_busy", i), {31'b0, rd_busy}, {31'b0, vecs[i].e_rdb});
            check($sformatf("v%0d rdy", i), {31'b0, wbck_if.gpr_wbck_rdy}, 32'h1);
            next_cycle();
        end

        // Fill x1..x31, then mark x20 pending.
        drive_idle();
        for (int i = 1; i < 32; i++) begin
            wbck_if.gpr_wbck_vld   = 1'b1;
            wbck_if.gpr_wbck_idx   = 5'(i);
            wbck_if.gpr_wbck_wdata = 32'h1000_0000 | 32'(i);
            next_cycle();
        end
        drive_idle();
        rs1_idx     = 5'd31;
        rs2_idx     = 5'd1;
        disp_vld    = 1'b1;
        disp_rd_en  = 1'b1;
        disp_rd_idx = 5'd20;
        #1;
        check("fill x31", rs1_rdata, 32'h1000_001F);
        check("fill x1", rs2_rdata, 32'h1000_0001);
        next_cycle();
        disp_vld   = 1'b0;
        disp_rd_en = 1'b0;
        rs2_idx    = 5'd20;
        #1;
        check("x20 pending", {31'b0, rs2_busy}, 32'h1);
        check("x20 rd_busy", {31'b0, rd_busy}, 32'h1);

        // Asynchronous reset pulse between edges.
        #1;
        rst_n = 1'b0;
        #1;
        check("async rst rdy", {31'b0, wbck_if.gpr_wbck_rdy}, 32'h0);
        check("async rst x31", rs1_rdata, 32'h0);
        check("async rst x20", rs2_rdata, 32'h0);
        check("async rst busy", {29'b0, rs1_busy, rs2_busy, rd_busy}, 32'h0);
        rs1_idx = 5'd1;
        #1;
        check("async rst x1", rs1_rdata, 32'h0);
        rst_n = 1'b1;
        next_cycle();
        check("rdy after async rst", {31'b0, wbck_if.gpr_wbck_rdy}, 32'h1);
        check("x1 still cleared", rs1_rdata, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_lnrv_exu_gpr

// File: doc/lnrv_exu_gpr.md
# lnrv_exu_gpr

Integer register file on the receiving end of the EXU writeback channel. It accepts `gpr_wbck_*` vld/rdy write transactions, holds the 32×32 architectural GPRs with x0 hardwired to zero, and serves two combinational read ports with same-cycle write bypass. A pending-write scoreboard, set at dispatch and cleared at writeback, reports RAW and WAW hazards to the issue stage.

## Interface
Parameters:
- `XLEN`, 32, register width.
- `GPR_NUM`, 32, number of registers; index width is `$clog2(GPR_NUM)` (5).
- `BYPASS_EN`, 1, enables write-to-read forwarding and busy suppression on a same-cycle write.

Ports (one clock; reset is asynchronous and active-low):
- `clk` input 1: clock.
- `rst_n` input 1: asynchronous active-low reset.
- `gpr_wbck_vld` input 1: a write request is valid.
- `gpr_wbck_rdy` output 1: write port can accept.
- `gpr_wbck_idx` input 5: destination register.
- `gpr_wbck_wdata` input XLEN: write data.
- `rs1_idx` input 5: read port 1 index.
- `rs2_idx` input 5: read port 2 index.
- `rs1_rdata` output XLEN: read port 1 data.
- `rs2_rdata` output XLEN: read port 2 data.
- `disp_vld` input 1: an instruction is dispatched this cycle.
- `disp_rd_en` input 1: the dispatched instruction writes rd.
- `disp_rd_idx` input 5: rd of the dispatched instruction.
- `rs1_busy` output 1: rs1 has an outstanding write (RAW).
- `rs2_busy` output 1: rs2 has an outstanding write (RAW).
- `rd_busy` output 1: `disp_rd_idx` has an outstanding write (WAW).
- `flush` input 1: synchronous clear of all scoreboard bits.

## Operation
- Write fire: `wb_fire = gpr_wbck_vld & gpr_wbck_rdy`. On `wb_fire` with idx≠0, `gpr[idx] <= wdata` at the next edge. Writes to idx 0 are accepted (handshake completes) and discarded.
- `gpr_wbck_rdy` is a register. It resets to 0 and becomes 1 on the first clock edge after `rst_n` deasserts, then stays 1. There is no internal backpressure.
- Reads are combinational. Index 0 returns 0. If `BYPASS_EN` and `wb_fire` with `gpr_wbck_idx == rsN_idx ≠ 0`, `rsN_rdata = gpr_wbck_wdata`. Otherwise `rsN_rdata = gpr[rsN_idx]`.
- Scoreboard `busy[31:1]`; `busy[0]` is constant 0.
  - Set: `disp_vld & disp_rd_en & disp_rd_idx≠0`.
  - Clear: `wb_fire & gpr_wbck_idx≠0`.
  - Same idx set and cleared in the same cycle: set wins, because the newer instruction is now pending.
  - Set and clear on different idx in the same cycle: both take effect.
  - `flush`: all busy bits go to 0 next cycle and override a same-cycle set. Register contents are untouched, and a same-cycle write still commits.
- `rsN_busy = busy[rsN_idx] & ~(BYPASS_EN & wb_fire & gpr_wbck_idx==rsN_idx)`.
- `rd_busy = busy[disp_rd_idx]`, evaluated without bypass. Dispatch stalls on WAW are the issue stage's decision; this block only reports.
- Multiple outstanding writes to the same idx are not tracked; the issue stage must stall on `rd_busy`.

## Timing
- Reset values:
  - all `gpr` = 0
  - `busy` = 0
  - `gpr_wbck_rdy` = 0
  - outputs `rsN_rdata` = 0 and all busy outputs = 0, as a consequence of the above
- Write latency: the value is visible from the register array one cycle after `wb_fire`. With `BYPASS_EN` it is visible on the read port in the same cycle.
- Scoreboard latency: a busy bit set by dispatch at cycle N is visible at N+1. A clear is visible combinationally at N (bypass) and in the array at N+1.
- `rst_n` asserted mid-operation: all state clears immediately, `gpr_wbck_rdy` drops asynchronously, and an in-flight write is lost.
- Read and write combinational paths do not depend on `disp_*`. There is no combinational loop from `gpr_wbck_vld` to `gpr_wbck_rdy`.

## Structure
- Shared package / `lnrv_def.v`: `` `XLEN ``, `` `GPR_IDX_W `` (5), `` `GPR_NUM `` (32).
- One natural sub-module: `lnrv_gpr_scbd`, the busy-bit vector with set/clear/flush and three lookup ports. The register array and bypass muxes live in the top.

## Test plan
- Reset then write: release `rst_n`, check `gpr_wbck_rdy`=0 for one cycle then 1. Write x5=0xDEADBEEF → reading `rs1_idx`=5 returns 0xDEADBEEF in the same cycle (bypass) and on the following cycle.
- x0 write: write idx0=0x12345678 → handshake completes, and `rs1_idx`=0 and `rs2_idx`=0 read 0 in every cycle.
- RAW scoreboard: dispatch rd=7 → next cycle `rs2_idx`=7 gives `rs2_busy`=1. Writeback x7=0x55 → `rs2_busy`=0 in the same cycle with `rs2_rdata`=0x55, and the busy bit is cleared the cycle after.
- Set/clear collision: `wb_fire` to x9 and dispatch rd=9 in the same cycle → next cycle `busy[9]`=1. Also check `rd_busy`=1 for `disp_rd_idx`=9.
- Flush: dispatch rd=3,4,10 over three cycles, then assert `flush` together with dispatch rd=11 → next cycle all busy outputs are 0, including for 11. Registers are unchanged.
- Async reset mid-run: after writes to x1..x31, pulse `rst_n` low between clock edges → all reads return 0, busy is 0, and `gpr_wbck_rdy`=0 immediately.
